// File: rtl/hash_enc_pkg.sv
// Shared types and default constants for the hash-encoding pipeline.
package hash_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } addr_gen_state_e;

  typedef logic [63:0] byte_addr_t;

  localparam int unsigned DEF_TABLE_ENTRIES = 4096;
  localparam byte_addr_t  DEF_TABLE_MASK    = 64'(DEF_TABLE_ENTRIES - 1);
  localparam byte_addr_t  DEF_LEVEL_OFFSET  = 64'd16384;

endpackage

// File: rtl/hash_addr_calc.sv
// Combinational (level, index) -> byte address for one feature-table entry.
// Index bits above the table size are dropped so the index wraps in its table.
module hash_addr_calc
  import hash_enc_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         LW            = 4,
  parameter int         TABLE_ENTRIES = DEF_TABLE_ENTRIES,
  parameter int         ENTRY_BYTES   = 4,
  parameter byte_addr_t LEVEL_OFFSET  = DEF_LEVEL_OFFSET,
  parameter byte_addr_t BASE_ADDR     = 64'd0
) (
  input  logic [LW-1:0]         i_level,
  input  logic [DATA_WIDTH-1:0] i_idx,
  output byte_addr_t            o_addr
);

  localparam byte_addr_t MASK = 64'(TABLE_ENTRIES - 1);

  byte_addr_t w_idx64;
  byte_addr_t w_level_base;
  byte_addr_t w_entry_off;

  assign w_idx64      = 64'(i_idx);
  assign w_level_base = byte_addr_t'(i_level) * LEVEL_OFFSET;
  assign w_entry_off  = (w_idx64 & MASK) * byte_addr_t'(ENTRY_BYTES);
  assign o_addr       = BASE_ADDR + w_level_base + w_entry_off;

endmodule

// File: rtl/hash_level_addr_gen.sv
// Multi-level, multi-corner hash-table address generator.
// Latches one request (level + NUM_CORNERS indices) and streams one registered
// byte address per corner; the next request can load on the last-corner beat.
module hash_level_addr_gen
  import hash_enc_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         NUM_LEVELS    = 16,
  parameter int         NUM_CORNERS   = 8,
  parameter int         TABLE_ENTRIES = DEF_TABLE_ENTRIES,
  parameter int         ENTRY_BYTES   = 4,
  parameter byte_addr_t LEVEL_OFFSET  = DEF_LEVEL_OFFSET,
  parameter byte_addr_t BASE_ADDR     = 64'd0,
  localparam int        LW            = (NUM_LEVELS  > 1) ? $clog2(NUM_LEVELS)  : 1,
  localparam int        CW            = (NUM_CORNERS > 1) ? $clog2(NUM_CORNERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LW-1:0]                     in_level,
  input  logic [NUM_CORNERS*DATA_WIDTH-1:0] in_idx,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [63:0]                       out_addr,
  output logic [CW-1:0]                     out_corner,
  output logic [LW-1:0]                     out_level,
  output logic                              out_last,
  output logic                              err_level
);

  addr_gen_state_e r_state;
  addr_gen_state_e w_state_nxt;

  logic [NUM_CORNERS-1:0][DATA_WIDTH-1:0] r_idx;
  logic [LW-1:0]                          r_level;
  logic [CW-1:0]                          r_corner;
  byte_addr_t                             r_addr;
  logic                                   r_last;
  logic                                   r_err;

  logic                  w_lvl_ok;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_out_fire;
  logic                  w_advance;
  logic [CW-1:0]         w_next_corner;
  logic [LW-1:0]         w_calc_level;
  logic [DATA_WIDTH-1:0] w_calc_idx;
  byte_addr_t            w_calc_addr;

  // Level range check widened by one bit so NUM_LEVELS itself is representable.
  assign w_lvl_ok      = {1'b0, in_level} < (LW+1)'(NUM_LEVELS);
  assign w_accept      = in_valid && in_ready;
  assign w_load        = w_accept && w_lvl_ok;
  assign w_out_fire    = out_valid && out_ready;
  assign w_advance     = w_out_fire && !r_last;
  assign w_next_corner = r_corner + 1'b1;

  // One address calculator: a fresh request uses its corner 0 straight from the
  // input; otherwise the latched request supplies the following corner.
  assign w_calc_level = w_load ? in_level : r_level;
  assign w_calc_idx   = w_load ? in_idx[DATA_WIDTH-1:0] : r_idx[w_next_corner];

  hash_addr_calc #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LW           (LW),
    .TABLE_ENTRIES(TABLE_ENTRIES),
    .ENTRY_BYTES  (ENTRY_BYTES),
    .LEVEL_OFFSET (LEVEL_OFFSET),
    .BASE_ADDR    (BASE_ADDR)
  ) u_calc (
    .i_level(w_calc_level),
    .i_idx  (w_calc_idx),
    .o_addr (w_calc_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave EMIT only on the last beat, unless a good request reloads it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = EMIT;
      EMIT:    if (w_out_fire && r_last) w_state_nxt = w_load ? EMIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready sees out_ready combinationally for zero-bubble reload.
  always_comb begin
    out_valid = (r_state == EMIT);
    in_ready  = (r_state == IDLE) || ((r_state == EMIT) && out_ready && r_last);
  end

  // Request latch, corner counter and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_level  <= '0;
      r_corner <= '0;
      r_addr   <= '0;
      r_last   <= 1'b0;
    end else if (w_load) begin
      r_idx    <= in_idx;
      r_level  <= in_level;
      r_corner <= '0;
      r_addr   <= w_calc_addr;
      r_last   <= (NUM_CORNERS == 1);
    end else if (w_advance) begin
      r_corner <= w_next_corner;
      r_addr   <= w_calc_addr;
      r_last   <= (w_next_corner == CW'(NUM_CORNERS - 1));
    end
  end

  // Single-cycle flag for a consumed request whose level is out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && !w_lvl_ok;
  end

  assign out_addr   = r_addr;
  assign out_corner = r_corner;
  assign out_level  = r_level;
  assign out_last   = r_last;
  assign err_level  = r_err;

endmodule
